pwm_capture: RTL and testbench



---
 rtl/pwm_pkg.sv | 15 +
 rtl/pwm_sync_edge.sv | 92 +++++++++
 rtl/pwm_capture.sv | 160 ++++++++++++++++
 tb/tb_pwm_capture.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared PWM definitions: capture FSM state encoding and the counter width
// common to the PWM generator and the capture stage.
package pwm_pkg;

    localparam int PWM_CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        STALL = 3'd4
    } cap_state_e;

endpackage

// File: rtl/pwm_sync_edge.sv
// Synchronises the asynchronous PWM input and produces registered rise/fall pulses.
// Optional debounce filter compiled in with PWM_CAPTURE_FILTER_EN.
module pwm_sync_edge #(
    parameter int SYNC_STAGES = 2
`ifdef PWM_CAPTURE_FILTER_EN
    , parameter int FILTER_LEN = 3
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_i,
    output logic rise_o,
    output logic fall_o,
    output logic level_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;
    logic                   clean_s;
    logic                   s_d_q;
    logic                   rise_q;
    logic                   fall_q;

    // Synchroniser chain on the raw input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_i};
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int RUN_W = $clog2(FILTER_LEN + 1);

    logic             filt_q;
    logic             filt_d;
    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_d;

    // Filtered level flips only after FILTER_LEN consecutive differing samples
    always_comb begin
        filt_d = filt_q;
        run_d  = {RUN_W{1'b0}};
        if (sync_s != filt_q) begin
            if (run_q == RUN_W'(FILTER_LEN - 1)) begin
                filt_d = sync_s;
                run_d  = {RUN_W{1'b0}};
            end else begin
                run_d = run_q + RUN_W'(1);
            end
        end else begin
            run_d = {RUN_W{1'b0}};
        end
    end

    // Filter state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= 1'b0;
            run_q  <= {RUN_W{1'b0}};
        end else begin
            filt_q <= filt_d;
            run_q  <= run_d;
        end
    end

    assign clean_s = filt_q;
`else
    assign clean_s = sync_s;
`endif

    // Delayed level and registered edge pulses; level is aligned with the pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_d_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s_d_q  <= clean_s;
            rise_q <= clean_s & ~s_d_q;
            fall_q <= ~clean_s & s_d_q;
        end
    end

    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign level_o = s_d_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of each completed PWM cycle and flags a stalled input.
// Optional input debounce filter is enabled with PWM_CAPTURE_FILTER_EN.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W       = PWM_CNT_W,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 65535
`ifdef PWM_CAPTURE_FILTER_EN
    , parameter int FILTER_LEN = 3
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             valid,
    output logic             stalled,
    output logic             level
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    logic       rise_s;
    logic       fall_s;
    logic       lvl_s;

    cap_state_e       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [CNT_W-1:0] hreg_q,   hreg_d;
    logic [CNT_W-1:0] high_q,   high_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q,  valid_d;
    logic             stalled_q, stalled_d;
    logic             level_q,  level_d;

    pwm_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
`ifdef PWM_CAPTURE_FILTER_EN
        , .FILTER_LEN (FILTER_LEN)
`endif
    ) u_sync_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .pwm_i   (pwm_in),
        .rise_o  (rise_s),
        .fall_o  (fall_s),
        .level_o (lvl_s)
    );

    // Next-state, counter and measurement-output logic
    always_comb begin
        state_d   = state_q;
        hreg_d    = hreg_q;
        high_d    = high_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        stalled_d = stalled_q;
        level_d   = level_q;
        if (rise_s) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q == TIMEOUT_C) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (!en) begin
            state_d   = IDLE;
            cnt_d     = {CNT_W{1'b0}};
            stalled_d = 1'b0;
            level_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARM;
                    cnt_d   = {CNT_W{1'b0}};
                end
                ARM: begin
                    if (rise_s) begin
                        state_d = HIGH;
                    end else begin
                        state_d = ARM;
                    end
                end
                HIGH: begin
                    if (fall_s) begin
                        hreg_d  = cnt_q;
                        state_d = LOW;
                    end else if (cnt_q == TIMEOUT_C) begin
                        state_d   = STALL;
                        stalled_d = 1'b1;
                        level_d   = lvl_s;
                    end else begin
                        state_d = HIGH;
                    end
                end
                LOW: begin
                    if (rise_s) begin
                        state_d  = HIGH;
                        period_d = cnt_q;
                        high_d   = hreg_q;
                        valid_d  = 1'b1;
                    end else if (cnt_q == TIMEOUT_C) begin
                        state_d   = STALL;
                        stalled_d = 1'b1;
                        level_d   = lvl_s;
                    end else begin
                        state_d = LOW;
                    end
                end
                STALL: begin
                    // The cycle that ends a stall is incomplete, so it is not reported
                    if (rise_s) begin
                        state_d   = HIGH;
                        stalled_d = 1'b0;
                        level_d   = 1'b0;
                    end else begin
                        level_d = lvl_s;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            hreg_q    <= {CNT_W{1'b0}};
            high_q    <= {CNT_W{1'b0}};
            period_q  <= {CNT_W{1'b0}};
            valid_q   <= 1'b0;
            stalled_q <= 1'b0;
            level_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hreg_q    <= hreg_d;
            high_q    <= high_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            stalled_q <= stalled_d;
            level_q   <= level_d;
        end
    end

    assign high_cnt   = high_q;
    assign period_cnt = period_q;
    assign valid      = valid_q;
    assign stalled    = stalled_q;
    assign level      = level_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: directed and random PWM waveforms compared
// each cycle against an edge-timestamp reference model.
module tb_pwm_capture;

    localparam int CNT_W = 16;
    localparam int SYNC  = 2;
    localparam int TO    = 200;
    localparam int LAT   = SYNC + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             pwm_in;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic             valid;
    logic             stalled;
    logic             level;

    int n_cmp = 0;
    int n_err = 0;
    int valid_seen = 0;

    // Reference model: input history plus timestamps of accepted edges
    logic             xh [LAT+2];
    bit               active, tracking, have_high, stall;
    int               rise_t, hi, edge_no;
    logic             m_valid, m_stalled, m_level;
    logic [CNT_W-1:0] m_high, m_period;

    pwm_capture #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC),
        .TIMEOUT     (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .pwm_in     (pwm_in),
        .high_cnt   (high_cnt),
        .period_cnt (period_cnt),
        .valid      (valid),
        .stalled    (stalled),
        .level      (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, edge_no);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < LAT + 2; i++) xh[i] = 1'b0;
        active = 0; tracking = 0; have_high = 0; stall = 0;
        rise_t = 0; hi = 0;
        m_valid = 1'b0; m_stalled = 1'b0; m_level = 1'b0;
        m_high = '0; m_period = '0;
    endtask

    // A pwm edge sampled at edge k is acted on by the measurement logic at edge k+LAT
    task automatic model_edge();
        logic r, f;
        for (int i = LAT + 1; i > 0; i--) xh[i] = xh[i-1];
        xh[0] = pwm_in;
        edge_no++;
        r = xh[LAT] & ~xh[LAT+1];
        f = ~xh[LAT] & xh[LAT+1];
        m_valid = 1'b0;
        if (!en) begin
            active = 0; tracking = 0; stall = 0;
            m_stalled = 1'b0; m_level = 1'b0;
        end else if (!active) begin
            active = 1;
        end else if (r) begin
            if (tracking && have_high && !stall) begin
                m_valid  = 1'b1;
                m_high   = CNT_W'(hi);
                m_period = CNT_W'(edge_no - rise_t);
            end
            rise_t = edge_no; tracking = 1; have_high = 0; stall = 0;
            m_stalled = 1'b0; m_level = 1'b0;
        end else if (tracking && !stall && f) begin
            hi = edge_no - rise_t;
            have_high = 1;
        end else if (tracking && !stall && (edge_no - rise_t >= TO)) begin
            stall = 1;
            m_stalled = 1'b1;
            m_level = xh[LAT];
        end else if (stall) begin
            m_level = xh[LAT];
        end
    endtask

    task automatic check_all();
        check("valid",      32'(valid),      32'(m_valid));
        check("high_cnt",   32'(high_cnt),   32'(m_high));
        check("period_cnt", 32'(period_cnt), 32'(m_period));
        check("stalled",    32'(stalled),    32'(m_stalled));
        check("level",      32'(level),      32'(m_level));
        if (valid) valid_seen++;
    endtask

    task automatic step(input logic p, input logic e_in);
        pwm_in = p;
        en     = e_in;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic hold(input logic p, input int n, input logic e_in);
        for (int i = 0; i < n; i++) step(p, e_in);
    endtask

    task automatic pwm_cycles(input int h, input int l, input int reps);
        for (int i = 0; i < reps; i++) begin
            hold(1'b1, h, 1'b1);
            hold(1'b0, l, 1'b1);
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; pwm_in = 1'b0;
        edge_no = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Steady 30/70 waveform
        hold(1'b0, 3, 1'b0);
        hold(1'b0, 5, 1'b1);
        valid_seen = 0;
        pwm_cycles(30, 70, 5);
        check("t1_valid_count", 32'(valid_seen), 32'd4);
        check("t1_high", 32'(high_cnt), 32'd30);
        check("t1_period", 32'(period_cnt), 32'd100);

        // Random phases, including single-cycle pulses
        for (int i = 0; i < 15; i++) begin
            pwm_cycles(int'($urandom_range(1, 40)), int'($urandom_range(1, 40)), 1);
        end

        // Stuck low, then recovery
        pwm_cycles(20, 20, 2);
        hold(1'b0, 250, 1'b1);
        check("t3_stalled", 32'(stalled), 32'd1);
        check("t3_level", 32'(level), 32'd0);
        pwm_cycles(30, 70, 2);
        check("t3_high", 32'(high_cnt), 32'd30);

        // Stuck high
        hold(1'b1, 250, 1'b1);
        check("t3b_stalled", 32'(stalled), 32'd1);
        check("t3b_level", 32'(level), 32'd1);
        hold(1'b0, 10, 1'b1);
        pwm_cycles(40, 60, 2);

        // Input already high when enabled
        hold(1'b1, 5, 1'b0);
        hold(1'b1, 10, 1'b1);
        hold(1'b0, 10, 1'b1);
        valid_seen = 0;
        pwm_cycles(40, 60, 2);
        check("t4_valid_count", 32'(valid_seen), 32'd1);
        check("t4_high", 32'(high_cnt), 32'd40);
        check("t4_period", 32'(period_cnt), 32'd100);

        // Enable dropped mid-high
        pwm_cycles(25, 25, 2);
        hold(1'b1, 10, 1'b1);
        hold(1'b1, 5, 1'b0);
        hold(1'b1, 5, 1'b1);
        hold(1'b0, 15, 1'b1);
        pwm_cycles(35, 15, 2);
        check("t5_high", 32'(high_cnt), 32'd35);

        // Asynchronous reset during the low phase
        pwm_cycles(30, 30, 2);
        hold(1'b0, 10, 1'b1);
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all();
        #1;
        rst_n = 1'b1;
        hold(1'b0, 5, 1'b1);
        valid_seen = 0;
        pwm_cycles(30, 30, 3);
        check("t6_valid_count", 32'(valid_seen), 32'd2);
        check("t6_period", 32'(period_cnt), 32'd60);

        // Two-cycle glitch inside a 50/50 waveform is measured unfiltered
        pwm_cycles(50, 50, 2);
        hold(1'b1, 50, 1'b1);
        hold(1'b0, 20, 1'b1);
        hold(1'b1, 2, 1'b1);
        hold(1'b0, 28, 1'b1);
        hold(1'b1, 5, 1'b1);
        check("t7_glitch_high", 32'(high_cnt), 32'd2);
        check("t7_glitch_period", 32'(period_cnt), 32'd30);
        hold(1'b1, 45, 1'b1);
        hold(1'b0, 50, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
